// File: rtl/bcd_conv_if.sv
// Handshake/result bundle for bcd_conv_seq.
//   start : request a conversion of acc (master -> slave)
//   acc   : 11-bit signed two's-complement value (master -> slave)
//   busy  : conversion in progress (slave -> master)
//   done  : one-cycle pulse, bcd/neg/ovf just updated (slave -> master)
//   bcd   : magnitude digits {hundreds, tens, ones} (slave -> master)
//   neg   : sign of converted value (slave -> master)
//   ovf   : magnitude exceeded 999 (slave -> master)
interface bcd_conv_if;
  logic        start;
  logic [10:0] acc;
  logic        busy;
  logic        done;
  logic [11:0] bcd;
  logic        neg;
  logic        ovf;

  modport master (output start, acc, input busy, done, bcd, neg, ovf);
  modport slave  (input start, acc, output busy, done, bcd, neg, ovf);
endinterface

// File: rtl/bcd_conv_seq.sv
// Sequential signed binary -> BCD converter (shift-and-add-3).
// A conversion takes 13 edges: sample, 11 shifts, load. Results hold
// until the next load or reset.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : bcd_conv_if.slave (start/acc in; busy/done/bcd/neg/ovf out)
// Build option:
//   BCD_RANGE_CHK_EN defined   -> magnitudes above 999 saturate bcd to 999
//                                 and raise ovf.
//   BCD_RANGE_CHK_EN undefined -> thousands digit is dropped, ovf stays 0.
module bcd_conv_seq (
  input  logic       clk,
  input  logic       rst,
  bcd_conv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state;
  logic [10:0] mag;
  logic [15:0] scratch;   // thousands nibble only feeds ovf/saturation
  logic [3:0]  cnt;
  logic        neg_r;
  logic        busy_r, done_r, neg_o, ovf_o;
  logic [11:0] bcd_o;

  logic [15:0] adj;
  logic [10:0] acc_abs;

  // -1024 negates to itself as an 11-bit pattern, which read unsigned is 1024.
  assign acc_abs = bus.acc[10] ? (~bus.acc + 11'd1) : bus.acc;

  // Add-3 correction applied before every shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++)
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      neg_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      bcd_o   <= '0;
      neg_o   <= 1'b0;
      ovf_o   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mag     <= acc_abs;
            neg_r   <= bus.acc[10];
            scratch <= '0;
            cnt     <= 4'd11;
            busy_r  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, mag} <= {adj[14:0], mag, 1'b0};
          cnt            <= cnt - 4'd1;
          if (cnt == 4'd1) state <= LOAD;
        end
        LOAD: begin
`ifdef BCD_RANGE_CHK_EN
          if (scratch[15:12] != 4'd0) begin
            bcd_o <= 12'h999;
            ovf_o <= 1'b1;
          end else begin
            bcd_o <= scratch[11:0];
            ovf_o <= 1'b0;
          end
`else
          bcd_o <= scratch[11:0];
          ovf_o <= 1'b0;
`endif
          // A zero magnitude is never reported as negative.
          neg_o  <= neg_r & (scratch != 16'd0);
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.bcd  = bcd_o;
  assign bus.neg  = neg_o;
  assign bus.ovf  = ovf_o;
endmodule

// File: tb/tb_bcd_conv_seq.sv
// Self-checking bench for bcd_conv_seq. Expected results are pushed to a
// scoreboard queue when a conversion is started and popped on done.
module tb_bcd_conv_seq;
  logic clk = 1'b0;
  logic rst = 1'b0;
  bcd_conv_if bus ();

  bcd_conv_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int done_cnt = 0;
  logic [13:0] exp_q[$];   // {ovf, neg, bcd}

  always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

  function automatic logic [13:0] model(input int v);
    int m;
    logic [11:0] b;
    logic n, o;
    m = (v < 0) ? -v : v;
    n = (v < 0) && (m != 0);
    o = 1'b0;
    b = 12'(((m / 100) % 10) << 8 | ((m / 10) % 10) << 4 | (m % 10));
`ifdef BCD_RANGE_CHK_EN
    if (m > 999) begin b = 12'h999; o = 1'b1; end
`endif
    return {o, n, b};
  endfunction

  // Returns the number of edges until done is seen, or -1 on timeout.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin edges = k; break; end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.acc = '0;
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else pass_cnt++;
    total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus.done); else pass_cnt++;
    total++; if ({bus.ovf, bus.neg, bus.bcd} !== 14'h0) $display("FAIL reset_outputs: got %0h expected 0", {bus.ovf, bus.neg, bus.bcd}); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_conv(input int v);
    int e;
    logic [13:0] ex;
    @(negedge clk);
    bus.start = 1'b1; bus.acc = v[10:0];
    exp_q.push_back(model(v));
    @(posedge clk); #1;
    total++; if (bus.busy !== 1'b1) $display("FAIL conv_busy_set(%0d): got %0b expected 1", v, bus.busy); else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b0; bus.acc = 11'($urandom);   // later acc changes must not matter
    wait_done(e);
    total++; if (e !== 12) $display("FAIL conv_latency(%0d): got %0d expected 12", v, e); else pass_cnt++;
    total++; if (bus.busy !== 1'b0) $display("FAIL conv_busy_clr(%0d): got %0b expected 0", v, bus.busy); else pass_cnt++;
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      if (e > 0) begin
        total++; if (bus.bcd !== ex[11:0]) $display("FAIL conv_bcd(%0d): got %03h expected %03h", v, bus.bcd, ex[11:0]); else pass_cnt++;
        total++; if (bus.neg !== ex[12]) $display("FAIL conv_neg(%0d): got %0b expected %0b", v, bus.neg, ex[12]); else pass_cnt++;
        total++; if (bus.ovf !== ex[13]) $display("FAIL conv_ovf(%0d): got %0b expected %0b", v, bus.ovf, ex[13]); else pass_cnt++;
      end
    end
    @(posedge clk); #1;
    total++; if (bus.done !== 1'b0) $display("FAIL conv_done_pulse(%0d): got %0b expected 0", v, bus.done); else pass_cnt++;
    total++; if (bus.bcd !== ex[11:0]) $display("FAIL conv_hold(%0d): got %03h expected %03h", v, bus.bcd, ex[11:0]); else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int e, d0;
    logic [13:0] ex;
    d0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.acc = 11'd123;
    exp_q.push_back(model(123));
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) begin bus.start = 1'b1; bus.acc = 11'd456; end
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    wait_done(e);
    total++; if (e !== 7) $display("FAIL ignore_latency: got %0d expected 7", e); else pass_cnt++;
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      total++; if (bus.bcd !== ex[11:0]) $display("FAIL ignore_bcd: got %03h expected %03h", bus.bcd, ex[11:0]); else pass_cnt++;
    end
    repeat (20) @(posedge clk);
    #1;
    total++; if (done_cnt - d0 !== 1) $display("FAIL ignore_single_done: got %0d expected 1", done_cnt - d0); else pass_cnt++;
    total++; if (bus.bcd !== 12'h123) $display("FAIL ignore_hold: got %03h expected 123", bus.bcd); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int d0;
    @(negedge clk);
    bus.start = 1'b1; bus.acc = 11'd777;
    @(posedge clk);
    @(negedge clk) bus.start = 1'b0;
    repeat (5) @(posedge clk);   // 5th shift edge
    #1 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %0b expected 0", bus.busy); else pass_cnt++;
    total++; if (bus.bcd !== 12'h000) $display("FAIL abort_bcd: got %03h expected 000", bus.bcd); else pass_cnt++;
    d0 = done_cnt;
    @(negedge clk) rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (done_cnt !== d0) $display("FAIL abort_no_done: got %0d expected %0d", done_cnt, d0); else pass_cnt++;
    test_conv(58);
  endtask

  task automatic test_back_to_back();
    int e, v, prev;
    logic [13:0] ex;
    @(negedge clk);
    bus.start = 1'b1; bus.acc = 11'd12;
    exp_q.push_back(model(12));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy[%0d]: got %0b expected 1", i, bus.busy); else pass_cnt++;
      @(negedge clk);
      if (i < 3) begin
        v = (i % 2 == 0) ? -34 : 12;
        bus.acc = v[10:0];
        exp_q.push_back(model(v));
      end else bus.start = 1'b0;
      wait_done(e);
      total++; if (e !== 12) $display("FAIL b2b_period[%0d]: got %0d expected 12", i, e); else pass_cnt++;
      if (exp_q.size() != 0) begin
        ex = exp_q.pop_front();
        total++; if ({bus.neg, bus.bcd} !== ex[12:0]) $display("FAIL b2b_result[%0d]: got %0b/%03h expected %0b/%03h", i, bus.neg, bus.bcd, ex[12], ex[11:0]); else pass_cnt++;
      end
    end
    prev = done_cnt;
    repeat (15) @(posedge clk);
    #1;
    total++; if (done_cnt - prev !== 1 || bus.busy !== 1'b0) $display("FAIL b2b_stop: got dones=%0d busy=%0b expected 1/0", done_cnt - prev, bus.busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_conv(999);
    test_conv(-407);
    test_conv(0);
    test_conv(1000);
    test_conv(-1024);
    test_conv(-1);
    test_conv(1023);
    test_conv(int'($urandom_range(0, 999)));
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    total++; if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
